pe_link_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one outbound tile link (e.g. a PE's 130-bit east port) among `NUM_REQ` requesters. It sits in front of a PE tile's `in_from_*` input and serialises whole packets from several sources onto the single link. Transfers use valid/ready handshakes on both sides, with one registered output stage. New grants are gated by `ap_start`.

---
 rtl/pe_link_arbiter.sv | 166 ++++++++++++++++
 tb/tb_pe_link_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pe_link_arbiter
// Description : Round-robin, packet-locked arbiter sharing one outbound tile
//               link among NUM_REQ requesters. Whole packets are serialised
//               through a single registered output stage; new grants are
//               gated by ap_start.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_link_arbiter #(
    parameter int DATA_WIDTH = 130,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    // Pointer value after reset: the search starts one past it, i.e. at 0.
    localparam logic [ID_WIDTH-1:0] C_RR_PTR_INIT = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_WIDTH-1:0]     r_rr_ptr;
    logic [ID_WIDTH-1:0]     r_grant_id;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_last;

    logic [ID_WIDTH-1:0]     w_winner;
    logic                    w_any_req;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_can_accept;
    logic                    w_xfer;
    logic                    w_arb_fire;

    // Round-robin search: each requester's distance from rr_ptr+1 (mod
    // NUM_REQ); the valid requester with the smallest distance wins. Only
    // indices below NUM_REQ are ever examined, so nothing else can be granted.
    always_comb begin : p_rr_search
        int w_dist;
        int w_best;
        w_winner  = '0;
        w_any_req = 1'b0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + 2 * NUM_REQ - 1 - int'(r_rr_ptr)) % NUM_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_winner  = ID_WIDTH'(i);
                w_any_req = 1'b1;
            end
        end
    end

    // Steer the granted requester's word, valid and last flag.
    always_comb begin : p_sel_mux
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_WIDTH'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The output stage can take a word when it is empty or draining this cycle.
    assign w_can_accept = (r_state == ST_GRANT) && (!r_out_valid || out_ready);
    assign w_xfer       = w_can_accept && w_sel_valid;
    assign w_arb_fire   = (r_state == ST_IDLE) && ap_start && w_any_req;

    // Only the granted requester ever sees ready; all bits are low in IDLE.
    always_comb begin : p_req_ready
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_can_accept && (r_grant_id == ID_WIDTH'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until the last word moves.
    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_fire) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_xfer && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin : p_fsm_state
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant index and round-robin pointer both capture the winner.
    always_ff @(posedge clk or negedge reset) begin : p_grant
        if (!reset) begin
            r_grant_id <= '0;
            r_rr_ptr   <= C_RR_PTR_INIT;
        end else if (w_arb_fire) begin
            r_grant_id <= w_winner;
            r_rr_ptr   <= w_winner;
        end
    end

    // Output register: load on transfer, drain when downstream accepts.
    always_ff @(posedge clk or negedge reset) begin : p_out_reg
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_pe_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_link_arbiter
// Description : Self-checking bench for pe_link_arbiter. A cycle-level
//               behavioural model plus a per-requester stream scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_link_arbiter;

    localparam int DW = 130;
    localparam int NR = 4;
    localparam int IW = 2;

    logic                clk;
    logic                reset;
    logic                ap_start;
    logic [NR-1:0]       req_valid;
    logic [NR*DW-1:0]    req_data;
    logic [NR-1:0]       req_last;
    logic [NR-1:0]       req_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic                out_ready;
    logic [IW-1:0]       grant_id;
    logic                busy;

    pe_link_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit            m_busy;
    int            m_gid;
    int            m_ptr;
    bit            m_ov;
    bit            m_ol;
    logic [DW-1:0] m_od;

    // Requester drivers and stream scoreboard
    int  pk_len [NR];
    int  seq    [NR];
    int  exp_seq[NR];
    int  beats  [NR];
    bit  en     [NR];
    int  owner;
    int  grant_log[$];
    bit  prev_busy;

    function automatic logic [DW-1:0] mk_word(int r, int s);
        return {8'(r), 90'd0, 32'(s)};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_ptr = NR - 1; m_ov = 0; m_ol = 0; m_od = '0;
    endtask

    function automatic logic [NR-1:0] model_ready();
        logic [NR-1:0] r;
        r = '0;
        if (m_busy && (!m_ov || out_ready)) r[m_gid] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        bit xfer;
        bit lst;
        xfer = m_busy && (!m_ov || out_ready) && req_valid[m_gid];
        lst  = req_last[m_gid];
        if (xfer) begin
            m_ov = 1; m_od = req_data[m_gid*DW +: DW]; m_ol = lst;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (!m_busy) begin
            if (ap_start && (req_valid != 0)) begin
                for (int k = 1; k <= NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (req_valid[idx]) begin
                        m_gid = idx; m_ptr = idx; m_busy = 1;
                        break;
                    end
                end
            end
        end else if (xfer && lst) begin
            m_busy = 0;
        end
    endtask

    task automatic present();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = en[i] && (pk_len[i] != 0);
            req_data[i*DW +: DW] = mk_word(i, seq[i]);
            req_last[i] = (pk_len[i] == 1);
        end
    endtask

    task automatic driver_reset();
        for (int i = 0; i < NR; i++) begin
            pk_len[i] = 0; exp_seq[i] = seq[i];
        end
        owner = -1;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NR; i++) if (pk_len[i] != 0) return 0;
        return 1;
    endfunction

    // Downstream beat: each requester's words in order, packets contiguous.
    task automatic sb_beat();
        int r;
        int s;
        bit ok;
        r = int'(out_data[DW-1:DW-8]);
        s = int'(out_data[31:0]);
        ok = (r < NR) && (owner == -1 || owner == r);
        if (ok) ok = (s == exp_seq[r]);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stream: got req=%0d seq=%0d, want owner=%0d seq=%0d",
                     r, s, owner, (r < NR) ? exp_seq[r] : -1);
        end
        if (r < NR) begin
            exp_seq[r] = s + 1;
            beats[r]++;
            owner = out_last ? -1 : r;
        end
    endtask

    // One clock cycle: present inputs, check ready, step model, check outputs.
    task automatic tick();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] acc;
        present();
        #1;
        exp_rdy = model_ready();
        total++;
        if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
        end
        acc = req_valid & req_ready;
        if (out_valid === 1'b1 && out_ready) sb_beat();
        model_step();
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_last, busy} !== {m_ov, m_ol, m_busy}) begin
            bad++;
            $display("FAIL ctrl: got v/l/busy=%b%b%b want %b%b%b",
                     out_valid, out_last, busy, m_ov, m_ol, m_busy);
        end
        total++;
        if (grant_id !== IW'(m_gid)) begin
            bad++;
            $display("FAIL grant_id: got %0d want %0d", grant_id, m_gid);
        end
        total++;
        if (out_data !== m_od) begin
            bad++;
            $display("FAIL out_data: got %h want %h", out_data, m_od);
        end
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                seq[i]++; pk_len[i]--;
            end
        end
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && out_valid === 1'b0 && all_done()) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL %s timeout: got busy=%b want idle", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 0; ap_start = 0; out_ready = 0;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < NR; i++) begin
            pk_len[i] = 0; seq[i] = 0; exp_seq[i] = 0; beats[i] = 0; en[i] = 1;
        end
        owner = -1; prev_busy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_last, busy, grant_id, req_ready} !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset: got v=%b l=%b busy=%b gid=%0d rdy=%b want zeros",
                     out_valid, out_last, busy, grant_id, req_ready);
        end
        reset = 1;
    endtask

    task automatic test_first_grant();
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        ap_start = 1; out_ready = 1;
        for (int i = 0; i < NR; i++) pk_len[i] = 1;
        grant_log.delete();
        tick();
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== mk_word(0, 0)) begin
            bad++;
            $display("FAIL first_latency: got v=%b d=%h want v=1 d=%h",
                     out_valid, out_data, mk_word(0, 0));
        end
        wait_idle("first_grant");
        pk_len[0] = 1;
        wait_idle("first_grant_wrap");
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
                bad++;
                $display("FAIL grant_order[%0d]: got %0d want %0d", i,
                         (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_packet_lock();
        int n;
        grant_log.delete();
        pk_len[2] = 3;
        tick();
        pk_len[1] = 2;
        n = 0;
        while (pk_len[2] > 1 && n < 20) begin tick(); n++; end
        en[2] = 0;
        tick();
        tick();
        en[2] = 1;
        wait_idle("packet_lock");
        total++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 1) begin
            bad++;
            $display("FAIL lock_order: got n=%0d first=%0d want 2 then 1",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        int b0;
        int n;
        b0 = beats[3];
        pk_len[3] = 4;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        held = out_data;
        for (int c = 0; c < 3; c++) begin
            out_ready = 0;
            #1;
            total++;
            if (req_ready !== '0) begin
                bad++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=%h",
                         c, out_valid, out_data, held);
            end
        end
        out_ready = 1;
        wait_idle("backpressure");
        total++;
        if (beats[3] != b0 + 4) begin
            bad++;
            $display("FAIL bp_count: got %0d want %0d", beats[3] - b0, 4);
        end
    endtask

    task automatic test_ap_start();
        int b0;
        int n;
        b0 = beats[0];
        pk_len[0] = 4;
        tick();
        tick();
        ap_start = 0;
        n = 0;
        while (beats[0] < b0 + 4 && n < 40) begin tick(); n++; end
        total++;
        if (beats[0] != b0 + 4) begin
            bad++;
            $display("FAIL ap_count: got %0d want 4", beats[0] - b0);
        end
        pk_len[1] = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (busy !== 1'b0 || req_ready !== '0) begin
                bad++;
                $display("FAIL ap_gate[%0d]: got busy=%b rdy=%b want 0 0000", c, busy, req_ready);
            end
        end
        ap_start = 1;
        tick();
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL ap_resume: got busy=%b gid=%0d want 1 1", busy, grant_id);
        end
        wait_idle("ap_start");
    endtask

    task automatic test_wrap();
        pk_len[3] = 1;
        wait_idle("wrap_pre");
        pk_len[0] = 1;
        pk_len[2] = 1;
        tick();
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL wrap: got busy=%b gid=%0d want 1 0", busy, grant_id);
        end
        wait_idle("wrap");
    endtask

    task automatic test_reset_mid();
        pk_len[1] = 3;
        tick();
        tick();
        reset = 0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: got v=%b busy=%b gid=%0d want 0 0 0",
                     out_valid, busy, grant_id);
        end
        driver_reset();
        present();
        model_reset();
        prev_busy = 0;
        #3;
        reset = 1;
        pk_len[2] = 1;
        pk_len[3] = 1;
        tick();
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL post_reset_grant: got busy=%b gid=%0d want 1 2", busy, grant_id);
        end
        wait_idle("reset_mid");
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (pk_len[i] == 0 && $urandom_range(3) == 0) pk_len[i] = 1 + $urandom_range(3);
                en[i] = ($urandom_range(4) != 0);
            end
            out_ready = ($urandom_range(9) < 7);
            ap_start  = ($urandom_range(9) < 9);
            tick();
        end
        ap_start = 1; out_ready = 1;
        for (int i = 0; i < NR; i++) en[i] = 1;
        wait_idle("random_drain");
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_packet_lock();
        test_backpressure();
        test_ap_start();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
